// File: rtl/lsu_stall_ctrl.sv
// Load/store unit stall controller: issues one memory access per M-stage instruction and holds the pipeline until it completes.
// Optional macro LSU_TIMEOUT_EN adds an 8-bit ack watchdog that ends a hung access with a bus-error pulse.
module lsu_stall_ctrl (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [2:0]  i_slt_sl_M,
  input  logic        i_ld_unsigned_M,
  input  logic        i_flush_M,
  input  logic [31:0] i_addr_M,
  input  logic [31:0] i_wdata_M,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_bmask,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_stall_M,
  output logic [31:0] o_ld_data_M,
  output logic        o_misalign,
  output logic        o_bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [2:0] ACC_SB = 3'b001;
  localparam logic [2:0] ACC_SH = 3'b010;
  localparam logic [2:0] ACC_SW = 3'b110;
  localparam logic [2:0] ACC_LB = 3'b011;
  localparam logic [2:0] ACC_LH = 3'b100;
  localparam logic [2:0] ACC_LW = 3'b101;

  function automatic logic [3:0] lane_mask(input logic [2:0] acc, input logic [1:0] off);
    case (acc)
      ACC_SB, ACC_LB: lane_mask = 4'b0001 << off;
      ACC_SH, ACC_LH: lane_mask = off[1] ? 4'b1100 : 4'b0011;
      default:        lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] st_data(input logic [2:0] acc, input logic [31:0] wd);
    case (acc)
      ACC_SB:  st_data = {4{wd[7:0]}};
      ACC_SH:  st_data = {2{wd[15:0]}};
      default: st_data = wd;
    endcase
  endfunction

  function automatic logic [31:0] ld_ext(input logic [2:0] acc, input logic [1:0] off,
                                         input logic uns, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{off, 3'b000} +: 8];
    h = off[1] ? rd[31:16] : rd[15:0];
    case (acc)
      ACC_LB:  ld_ext = uns ? {24'd0, b} : {{24{b[7]}}, b};
      ACC_LH:  ld_ext = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: ld_ext = rd;
    endcase
  endfunction

  state_t      state_q;
  logic        mem_req_q, mem_we_q, uns_q, kill_q;
  logic [31:0] addr_q, wdata_q, ld_q;
  logic [3:0]  bmask_q;
  logic [2:0]  acc_q;
  logic [1:0]  off_q;
`ifdef LSU_TIMEOUT_EN
  logic [7:0]  cnt_q;
  logic        bus_err_q;
`endif

  logic        is_store, is_load, misal, start_d, acc_load_q;
  logic [31:0] wdata_d;
  logic [3:0]  bmask_d;

  assign is_store   = (i_slt_sl_M == ACC_SB) || (i_slt_sl_M == ACC_SH) || (i_slt_sl_M == ACC_SW);
  assign is_load    = (i_slt_sl_M == ACC_LB) || (i_slt_sl_M == ACC_LH) || (i_slt_sl_M == ACC_LW);
  assign misal      = (((i_slt_sl_M == ACC_SW) || (i_slt_sl_M == ACC_LW)) && (i_addr_M[1:0] != 2'b00)) ||
                      (((i_slt_sl_M == ACC_SH) || (i_slt_sl_M == ACC_LH)) && i_addr_M[0]);
  assign start_d    = (is_store || is_load) && !misal && !i_flush_M;
  assign wdata_d    = st_data(i_slt_sl_M, i_wdata_M);
  assign bmask_d    = lane_mask(i_slt_sl_M, i_addr_M[1:0]);
  assign acc_load_q = (acc_q == ACC_LB) || (acc_q == ACC_LH) || (acc_q == ACC_LW);

  // The IDLE stall must rise in the same cycle the access is decoded, so it is combinational.
  assign o_stall_M  = (state_q == REQ) || (!i_rst && (state_q == IDLE) && start_d);
  assign o_misalign = !i_rst && (state_q == IDLE) && (is_store || is_load) && misal && !i_flush_M;

  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_bmask = bmask_q;
  assign o_ld_data_M = ld_q;
`ifdef LSU_TIMEOUT_EN
  assign o_bus_err   = bus_err_q;
`else
  assign o_bus_err   = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      bmask_q   <= 4'd0;
      ld_q      <= 32'd0;
      acc_q     <= 3'd0;
      off_q     <= 2'd0;
      uns_q     <= 1'b0;
      kill_q    <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt_q     <= 8'd0;
      bus_err_q <= 1'b0;
`endif
    end else begin
`ifdef LSU_TIMEOUT_EN
      bus_err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (start_d) begin
            state_q   <= REQ;
            mem_req_q <= 1'b1;
            mem_we_q  <= is_store;
            addr_q    <= {i_addr_M[31:2], 2'b00};
            wdata_q   <= wdata_d;
            bmask_q   <= bmask_d;
            acc_q     <= i_slt_sl_M;
            off_q     <= i_addr_M[1:0];
            uns_q     <= i_ld_unsigned_M;
            kill_q    <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt_q     <= 8'd0;
`endif
          end
        end
        REQ: begin
          // A flush seen while waiting cannot cancel the bus cycle; it only discards the load result.
          kill_q <= kill_q || i_flush_M;
          if (i_mem_ack) begin
            state_q   <= DONE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (acc_load_q && !kill_q && !i_flush_M)
              ld_q <= ld_ext(acc_q, off_q, uns_q, i_mem_rdata);
          end
`ifdef LSU_TIMEOUT_EN
          else if (cnt_q == 8'd254) begin
            state_q   <= DONE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            bus_err_q <= 1'b1;
            ld_q      <= 32'd0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
`endif
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/lsu_stall_ctrl.md
LSU_STALL_CTRL -- requirements
Module: lsu_stall_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; both ports are listed first below.
REQ-002 i_clk  in  1  sole clock, rising edge.
REQ-003 i_rst  in  1  reset, asynchronous, active-high.
REQ-004 i_slt_sl_M  in  3  M-stage access type: 000 none, 001 SB, 010 SH, 110 SW, 011 LB, 100 LH, 101 LW, 111 reserved (treated as none).
REQ-005 i_ld_unsigned_M  in  1  zero-extend LB/LH results.
REQ-006 i_flush_M  in  1  M-stage instruction is killed.
REQ-007 i_addr_M / i_wdata_M  in  32/32  effective address / store data.
REQ-008 o_mem_req, o_mem_we  out  1/1  memory request, write strobe.
REQ-009 o_mem_addr, o_mem_wdata, o_mem_bmask  out  32/32/4  word address (bits[1:0]=00), lane-aligned data, byte mask.
REQ-010 i_mem_ack, i_mem_rdata  in  1/32  memory completion, read word (valid with ack).
REQ-011 o_stall_M  out  1  hold request to the hazard unit.
REQ-012 o_ld_data_M  out  32  extended load result.
REQ-013 o_misalign, o_bus_err  out  1/1  single-cycle exception pulses.

Function
REQ-014 The FSM SHALL have the states IDLE, REQ and DONE.
REQ-015 IDLE with a valid access, aligned and not flushed: o_stall_M=1 combinationally; REQ is entered next edge with request fields registered.
REQ-016 REQ: o_mem_req=1 and fields stable until the ack edge; o_stall_M=1; on i_mem_ack, the extended data is captured and DONE is entered.
REQ-017 DONE: o_stall_M=0 and o_ld_data_M valid for exactly one cycle; IDLE follows unconditionally, so the same instruction is never reissued.
REQ-018 Minimum stall SHALL be 2 cycles (ack in the first REQ cycle); each extra ack-wait cycle adds one.
REQ-019 Misaligned access (LW/SW with addr[1:0]≠00; LH/SH with addr[0]=1): no request, o_misalign pulses in IDLE, o_stall_M=0.
REQ-020 Byte masks: SB 0001<<addr[1:0] with the byte replicated on all lanes; SH 0011 or 1100 with the half replicated; SW 1111.
REQ-021 Loads: lane selected by addr[1:0]; LB/LH sign-extended unless i_ld_unsigned_M=1; LW passes through.
REQ-022 i_flush_M in IDLE SHALL suppress the request.
REQ-023 i_flush_M in REQ SHALL NOT drop the request; the transaction completes, o_ld_data_M stays at its old value, and DONE is still visited.
REQ-024 i_mem_ack outside REQ SHALL be ignored.
REQ-025 Stores SHALL leave o_ld_data_M unchanged.

Reset
REQ-026 Asserting i_rst SHALL immediately force IDLE; o_mem_req, o_mem_we, o_stall_M, o_misalign and o_bus_err become 0; o_mem_addr, o_mem_wdata, o_mem_bmask and o_ld_data_M become 0.
REQ-027 Reset during REQ SHALL abandon the transaction, and any later stray ack SHALL be ignored.
REQ-028 The first access after reset deassertion SHALL follow REQ-015.

Configuration
REQ-029 With LSU_TIMEOUT_EN defined: an 8-bit counter clears on REQ entry and increments each REQ cycle; when it reaches 255 without ack, o_mem_req drops, o_bus_err pulses, o_ld_data_M=0 and DONE is entered.
REQ-030 Without LSU_TIMEOUT_EN: REQ waits indefinitely, o_bus_err is tied 0, and no counter exists.

Verification
REQ-031 LW, addr 0x100, ack in first REQ cycle, rdata 0xDEADBEEF -> o_stall_M high 2 cycles, DONE with o_ld_data_M=0xDEADBEEF.
REQ-032 LB, addr 0x103, rdata 0x80xxxxxx, unsigned=0 then 1 -> 0xFFFFFF80 then 0x00000080.
REQ-033 SH, addr 0x202, wdata 0x1234 -> bmask 1100, o_mem_wdata 0x12341234, o_mem_addr 0x200, we=1.
REQ-034 LW, addr 0x101 -> o_misalign one-cycle pulse, o_mem_req never high, o_stall_M=0.
REQ-035 LW issued, i_rst pulsed during REQ, ack arrives 2 cycles later -> IDLE, no DONE, o_ld_data_M=0.
REQ-036 With LSU_TIMEOUT_EN, no ack -> o_bus_err after 255 REQ cycles, o_stall_M drops in DONE.
